// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 SPI sink: command opcodes, addressing
// mode encodings, command FSM states and power-on register defaults.
package ssd1306_pkg;

  typedef enum logic [1:0] {
    AM_HORIZ = 2'b00,
    AM_PAGE  = 2'b10
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2
  } cmd_state_e;

  // Opcodes that take arguments
  localparam logic [7:0] OP_CONTRAST  = 8'h81;
  localparam logic [7:0] OP_MEM_MODE  = 8'h20;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_MUX_RATIO = 8'hA8;
  localparam logic [7:0] OP_DISP_OFS  = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV   = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE = 8'hD9;
  localparam logic [7:0] OP_VCOMH     = 8'hDB;
  localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;

  // Single-byte opcodes
  localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISP_ON   = 8'hAF;
  localparam logic [7:0] OP_NORMAL    = 8'hA6;
  localparam logic [7:0] OP_INVERT    = 8'hA7;
  localparam logic [7:0] OP_RESUME    = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON = 8'hA5;
  localparam logic [7:0] OP_SEG_NORM  = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP = 8'hA1;
  localparam logic [7:0] OP_COM_NORM  = 8'hC0;
  localparam logic [7:0] OP_COM_REV   = 8'hC8;

  localparam logic [7:0] CONTRAST_RST = 8'h7F;
  localparam logic [5:0] MUX_RST      = 6'd63;

endpackage

// File: rtl/ssd1306_spi_sink_byte_rx.sv
// SPI byte receiver.
// Synchronises every SPI pin, detects sclk rising edges while cs is low and
// assembles MSB-first bytes. byte_valid pulses one cycle after the edge that
// carried bit 0, with byte_data/byte_dc held until the next byte.
// Ports: clk, rst_n (async low); spi_* raw pins; soft_rst = synchronised
// panel reset (active high); byte_valid, byte_data[7:0], byte_dc.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_sdin,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_reset_n,
  output logic       soft_rst,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  // Pin order {reset_n, dc, cs, sdin, sclk}; sclk and cs idle high.
  localparam logic [4:0] SYNC_RST = 5'b00101;

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic       sclk_s, sdin_s, cs_s, dc_s;
  logic       sclk_prev_q, rise;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d, valid_q, valid_d;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0],
                     {spi_reset_n, spi_dc, spi_cs, spi_sdin, spi_sclk}};
  assign sclk_s   = sync_q[SYNC_STAGES-1][0];
  assign sdin_s   = sync_q[SYNC_STAGES-1][1];
  assign cs_s     = sync_q[SYNC_STAGES-1][2];
  assign dc_s     = sync_q[SYNC_STAGES-1][3];
  assign soft_rst = ~sync_q[SYNC_STAGES-1][4];
  assign rise     = sclk_s & ~sclk_prev_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dc_d      = dc_q;
    valid_d   = 1'b0;
    // The final edge still completes the byte if cs rises in the same cycle.
    if (rise && (!cs_s || bit_cnt_q == 3'd7)) begin
      shift_d   = {shift_q[5:0], sdin_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d  = {shift_q, sdin_s};
        dc_d    = dc_s;
        valid_d = 1'b1;
      end
    end else if (cs_s) begin
      bit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{SYNC_RST}};
      sclk_prev_q <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_q      <= 8'd0;
      dc_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_s;
      if (soft_rst) begin
        bit_cnt_q <= 3'd0;
        shift_q   <= 7'd0;
        byte_q    <= 8'd0;
        dc_q      <= 1'b0;
        valid_q   <= 1'b0;
      end else begin
        bit_cnt_q <= bit_cnt_d;
        shift_q   <= shift_d;
        byte_q    <= byte_d;
        dc_q      <= dc_d;
        valid_q   <= valid_d;
      end
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = byte_q;
  assign byte_dc    = dc_q;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 4-wire SPI sink: command decoder, register shadow and frame-buffer
// address generator behind the spi_byte_rx deserialiser.
// Ports: clk, rst_n (async low); spi_sclk/sdin/cs/dc/reset_n pins;
// fb_we/fb_addr/fb_wdata frame-buffer write port; register shadow outputs
// and a one-cycle cmd_unknown pulse.
module ssd1306_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_sdin,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_reset_n,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       display_on,
  output logic       invert,
  output logic       entire_on,
  output logic       seg_remap,
  output logic       com_rev,
  output logic [7:0] contrast,
  output logic [5:0] start_line,
  output logic [5:0] mux_ratio,
  output logic       charge_pump,
  output logic       cmd_unknown
);
  import ssd1306_pkg::*;

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  typedef struct packed {
    cmd_state_e    state;
    logic [7:0]    op;
    logic [7:0]    arg1;
    addr_mode_e    mode;
    logic [CW-1:0] col, col_start, col_end;
    logic [PW-1:0] page, page_start, page_end;
    logic          fb_we;
    logic [9:0]    fb_addr;
    logic [7:0]    fb_wdata;
    logic          display_on, invert, entire_on, seg_remap, com_rev;
    logic [7:0]    contrast;
    logic [5:0]    start_line, mux_ratio;
    logic          charge_pump, cmd_unknown;
  } regs_t;

  localparam regs_t REG_RST = '{
    state: ST_IDLE, op: 8'd0, arg1: 8'd0, mode: AM_PAGE,
    col: '0, col_start: '0, col_end: CW'(COLS-1),
    page: '0, page_start: '0, page_end: PW'(PAGES-1),
    fb_we: 1'b0, fb_addr: 10'd0, fb_wdata: 8'd0,
    display_on: 1'b0, invert: 1'b0, entire_on: 1'b0, seg_remap: 1'b0,
    com_rev: 1'b0, contrast: CONTRAST_RST, start_line: 6'd0,
    mux_ratio: MUX_RST, charge_pump: 1'b0, cmd_unknown: 1'b0
  };

  logic       soft_rst, byte_valid, byte_dc;
  logic [7:0] rx_byte;
  regs_t      r_q, r_d;
  logic [CW-1:0] col_inc;
  logic [PW-1:0] page_inc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_sdin   (spi_sdin),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_reset_n(spi_reset_n),
    .soft_rst   (soft_rst),
    .byte_valid (byte_valid),
    .byte_data  (rx_byte),
    .byte_dc    (byte_dc)
  );

  // Pointer increments wrap modulo the panel size so end < start windows work.
  assign col_inc  = (r_q.col  == CW'(COLS-1))  ? '0 : r_q.col  + 1'b1;
  assign page_inc = (r_q.page == PW'(PAGES-1)) ? '0 : r_q.page + 1'b1;

  always_comb begin
    r_d             = r_q;
    r_d.fb_we       = 1'b0;
    r_d.cmd_unknown = 1'b0;
    if (soft_rst) begin
      r_d = REG_RST;
    end else if (byte_valid) begin
      if (byte_dc) begin
        // Data aborts any pending argument and is still written.
        r_d.state    = ST_IDLE;
        r_d.fb_we    = 1'b1;
        r_d.fb_addr  = 10'(32'(r_q.page) * COLS + 32'(r_q.col));
        r_d.fb_wdata = rx_byte;
        if (r_q.col == r_q.col_end) begin
          r_d.col = r_q.col_start;
          if (r_q.mode == AM_HORIZ)
            r_d.page = (r_q.page == r_q.page_end) ? r_q.page_start : page_inc;
        end else begin
          r_d.col = col_inc;
        end
      end else begin
        case (r_q.state)
          ST_ARG1: begin
            r_d.state = ST_IDLE;
            case (r_q.op)
              OP_CONTRAST:  r_d.contrast    = rx_byte;
              OP_MUX_RATIO: r_d.mux_ratio   = rx_byte[5:0];
              OP_CHG_PUMP:  r_d.charge_pump = rx_byte[2];
              OP_MEM_MODE: begin
                if (rx_byte[1])
                  r_d.mode = rx_byte[0] ? r_q.mode : AM_PAGE;
                else
                  r_d.mode = AM_HORIZ;
              end
              OP_COL_ADDR, OP_PAGE_ADDR: begin
                r_d.arg1  = rx_byte;
                r_d.state = ST_ARG2;
              end
              default: ;  // D3/D5/D9/DB arguments are swallowed
            endcase
          end
          ST_ARG2: begin
            r_d.state = ST_IDLE;
            if (r_q.op == OP_COL_ADDR) begin
              r_d.col_start = r_q.arg1[CW-1:0];
              r_d.col_end   = rx_byte[CW-1:0];
              r_d.col       = r_q.arg1[CW-1:0];
            end else begin
              r_d.page_start = r_q.arg1[PW-1:0];
              r_d.page_end   = rx_byte[PW-1:0];
              r_d.page       = r_q.arg1[PW-1:0];
            end
          end
          default: begin
            if (rx_byte[7:6] == 2'b01) begin
              r_d.start_line = rx_byte[5:0];
            end else begin
              case (rx_byte)
                OP_DISP_OFF:  r_d.display_on = 1'b0;
                OP_DISP_ON:   r_d.display_on = 1'b1;
                OP_NORMAL:    r_d.invert     = 1'b0;
                OP_INVERT:    r_d.invert     = 1'b1;
                OP_RESUME:    r_d.entire_on  = 1'b0;
                OP_ENTIRE_ON: r_d.entire_on  = 1'b1;
                OP_SEG_NORM:  r_d.seg_remap  = 1'b0;
                OP_SEG_REMAP: r_d.seg_remap  = 1'b1;
                OP_COM_NORM:  r_d.com_rev    = 1'b0;
                OP_COM_REV:   r_d.com_rev    = 1'b1;
                OP_CONTRAST, OP_MEM_MODE, OP_COL_ADDR, OP_PAGE_ADDR,
                OP_MUX_RATIO, OP_DISP_OFS, OP_CLK_DIV, OP_PRECHARGE,
                OP_VCOMH, OP_CHG_PUMP: begin
                  r_d.op    = rx_byte;
                  r_d.state = ST_ARG1;
                end
                default: r_d.cmd_unknown = 1'b1;
              endcase
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= REG_RST;
    else        r_q <= r_d;
  end

  assign fb_we       = r_q.fb_we;
  assign fb_addr     = r_q.fb_addr;
  assign fb_wdata    = r_q.fb_wdata;
  assign display_on  = r_q.display_on;
  assign invert      = r_q.invert;
  assign entire_on   = r_q.entire_on;
  assign seg_remap   = r_q.seg_remap;
  assign com_rev     = r_q.com_rev;
  assign contrast    = r_q.contrast;
  assign start_line  = r_q.start_line;
  assign mux_ratio   = r_q.mux_ratio;
  assign charge_pump = r_q.charge_pump;
  assign cmd_unknown = r_q.cmd_unknown;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Directed bench for ssd1306_spi_sink. Stimulus pushes expected frame-buffer
// writes into a queue; a negedge monitor pops and compares every fb_we.
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       spi_sclk = 1'b1, spi_sdin = 1'b0, spi_cs = 1'b1;
  logic       spi_dc = 1'b0, spi_reset_n = 1'b1;
  logic       fb_we, display_on, invert, entire_on, seg_remap, com_rev;
  logic       charge_pump, cmd_unknown;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  logic [5:0] start_line, mux_ratio;

  int checks = 0, errors = 0;
  int unk_pulses = 0, unk_long = 0;
  logic unk_prev = 1'b0;
  logic [17:0] exp_q[$];

  ssd1306_spi_sink dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_sdin(spi_sdin),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_reset_n(spi_reset_n),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .invert(invert), .entire_on(entire_on),
    .seg_remap(seg_remap), .com_rev(com_rev), .contrast(contrast),
    .start_line(start_line), .mux_ratio(mux_ratio),
    .charge_pump(charge_pump), .cmd_unknown(cmd_unknown)
  );

  always #5 clk = ~clk;

  // Monitor: scoreboard for writes, pulse-width tracking for cmd_unknown.
  always @(negedge clk) begin
    logic [17:0] e;
    if (cmd_unknown === 1'b1) begin
      if (unk_prev) unk_long++;
      else          unk_pulses++;
    end
    unk_prev = (cmd_unknown === 1'b1);
    if (fb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fb_write unexpected: addr=%h data=%h, required none",
                 fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({fb_addr, fb_wdata} !== e) begin
          errors++;
          $display("FAIL fb_write actual addr=%h data=%h required addr=%h data=%h",
                   fb_addr, fb_wdata, e[17:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    spi_cs = 1'b0;
    spi_dc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      spi_sclk = 1'b0;
      spi_sdin = b[i];
      #20;
      spi_sclk = 1'b1;
      #20;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
    spi_cs = 1'b1;
    #20;
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic data(input logic [7:0] b, input logic [9:0] addr);
    exp_q.push_back({addr, b});
    send_byte(b, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".fb_we"},       32'(fb_we),       32'd0);
    chk({tag, ".fb_addr"},     32'(fb_addr),     32'd0);
    chk({tag, ".fb_wdata"},    32'(fb_wdata),    32'd0);
    chk({tag, ".display_on"},  32'(display_on),  32'd0);
    chk({tag, ".invert"},      32'(invert),      32'd0);
    chk({tag, ".entire_on"},   32'(entire_on),   32'd0);
    chk({tag, ".seg_remap"},   32'(seg_remap),   32'd0);
    chk({tag, ".com_rev"},     32'(com_rev),     32'd0);
    chk({tag, ".contrast"},    32'(contrast),    32'h7F);
    chk({tag, ".start_line"},  32'(start_line),  32'd0);
    chk({tag, ".mux_ratio"},   32'(mux_ratio),   32'd63);
    chk({tag, ".charge_pump"}, 32'(charge_pump), 32'd0);
    chk({tag, ".cmd_unknown"}, 32'(cmd_unknown), 32'd0);
  endtask

  logic [7:0] init_seq [23] = '{
    8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8,
    8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB, 8'h20, 8'h8D,
    8'h14, 8'hA4, 8'hAF
  };

  initial begin
    #22 rst_n = 1'b1;
    #100;
    chk_reset("por");

    // Driver init sequence
    foreach (init_seq[i]) cmd(init_seq[i]);
    #200;
    chk("init.contrast",    32'(contrast),    32'h7F);
    chk("init.com_rev",     32'(com_rev),     32'd1);
    chk("init.seg_remap",   32'(seg_remap),   32'd1);
    chk("init.mux_ratio",   32'(mux_ratio),   32'd63);
    chk("init.charge_pump", 32'(charge_pump), 32'd1);
    chk("init.display_on",  32'(display_on),  32'd1);
    chk("init.unknown",     32'(unk_pulses),  32'd0);

    // Horizontal mode fill; the 1025th byte wraps to address 0
    for (int i = 0; i < 1025; i++) data(8'(i), 10'(i));

    // Column window 0x10..0x13, page window 2..3
    cmd(8'h21); cmd(8'h10); cmd(8'h13);
    cmd(8'h22); cmd(8'h02); cmd(8'h03);
    begin
      logic [9:0] win [10] = '{10'h110, 10'h111, 10'h112, 10'h113, 10'h190,
                               10'h191, 10'h192, 10'h193, 10'h110, 10'h111};
      foreach (win[i]) data(8'hA0 + 8'(i), win[i]);
    end

    // Pending argument survives a cs toggle
    cmd(8'h81);
    spi_cs = 1'b0; #40; spi_cs = 1'b1; #40;
    cmd(8'h20);
    #200;
    chk("arg_cs.contrast", 32'(contrast), 32'h20);

    // Data byte aborts a pending argument and is still written
    cmd(8'h81);
    data(8'h55, 10'h112);
    cmd(8'hA7);
    #200;
    chk("abort.contrast", 32'(contrast), 32'h20);
    chk("abort.invert",   32'(invert),   32'd1);

    // Partial byte discarded by cs rising
    cmd(8'hAE);
    #200;
    chk("partial.off", 32'(display_on), 32'd0);
    send_bits(8'hA8, 5, 1'b0);
    spi_cs = 1'b1; #40;
    cmd(8'hAF);
    #200;
    chk("partial.on", 32'(display_on), 32'd1);

    // Unsupported opcode
    cmd(8'hFF);
    #200;
    chk("unknown.pulses", 32'(unk_pulses), 32'd1);
    chk("unknown.width",  32'(unk_long),   32'd0);

    // Soft reset mid-stream with an argument pending
    cmd(8'hA5); cmd(8'hA0); cmd(8'h81);
    send_bits(8'hF0, 3, 1'b0);
    spi_reset_n = 1'b0; #100;
    spi_reset_n = 1'b1; spi_cs = 1'b1; #100;
    chk_reset("soft");
    cmd(8'h4A);
    #200;
    chk("soft.contrast",   32'(contrast),   32'h7F);
    chk("soft.start_line", 32'(start_line), 32'h0A);
    data(8'h3C, 10'h000);
    data(8'h3D, 10'h001);
    #200;
    chk("drain.queue",     32'(exp_q.size()), 32'd0);
    chk("final.unknown",   32'(unk_pulses),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
